// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: FSM states,
// frame constants and the command bytes sent to the keyboard.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_BITS      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } tx_state_t;

    localparam int PS2_DATA_BITS   = 8;
    localparam int PS2_FRAME_FALLS = 10;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a one-cycle
// strobe on each falling edge of the synchronized clock.
module ps2_host_tx_sync (
    input  logic clk100,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_s,
    output logic dat_s,
    output logic fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    // Reset to 1 so an idle (pulled-up) bus never looks like an edge.
    always_ff @(posedge clk100) begin
        if (rst) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            dat_ff   <= {dat_ff[0], ps2_dat_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s = clk_ff[1];
    assign dat_s = dat_ff[1];
    assign fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, then 8 data bits, odd
// parity and stop clocked by the device, followed by an ACK check.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int RTS_US     = 1,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic [2:0] dbg_state
);

    localparam int INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int RTS_CYC     = CLK_HZ / 1_000_000 * RTS_US;
    localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int PH_W        = $clog2(INHIBIT_CYC + 1);
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

    // Handshake: tx_start is a one-cycle request, accepted only when the FSM
    // is idle and tx_busy is low; requests while busy are dropped, not queued.

    tx_state_t       state;
    logic [PH_W-1:0] ph_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [3:0]      bitcnt;
    logic [7:0]      shift;
    logic            parity;
    logic            clk_s;
    logic            dat_s;
    logic            fall;

    ps2_host_tx_sync u_sync (
        .clk100     (clk100),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .clk_s      (clk_s),
        .dat_s      (dat_s),
        .fall       (fall)
    );

    always_ff @(posedge clk100) begin
        if (rst) begin
            state      <= ST_IDLE;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ph_cnt     <= '0;
            to_cnt     <= '0;
            bitcnt     <= '0;
            shift      <= '0;
            parity     <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_busy    <= 1'b0;
                    if (tx_start && !tx_busy) begin
                        shift      <= tx_data;
                        parity     <= odd_parity(tx_data);
                        ph_cnt     <= '0;
                        tx_busy    <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (ph_cnt == PH_W'(INHIBIT_CYC - 1)) begin
                        ph_cnt     <= '0;
                        ps2_dat_oe <= 1'b1;
                        state      <= ST_RTS;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                ST_RTS: begin
                    // Data held low here is the start bit the device reads.
                    if (ph_cnt == PH_W'(RTS_CYC - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        bitcnt     <= '0;
                        to_cnt     <= '0;
                        state      <= ST_BITS;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                default: begin
                    // Timeout takes priority over any ACK sample in the same cycle.
                    if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        tx_error   <= 1'b1;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                        case (state)
                            ST_BITS: begin
                                if (fall) begin
                                    if (bitcnt < 4'(PS2_DATA_BITS))
                                        ps2_dat_oe <= ~shift[bitcnt[2:0]];
                                    else if (bitcnt == 4'(PS2_DATA_BITS))
                                        ps2_dat_oe <= ~parity;
                                    else
                                        ps2_dat_oe <= 1'b0;
                                    if (bitcnt == 4'(PS2_FRAME_FALLS - 1))
                                        state <= ST_ACK;
                                    if (bitcnt != 4'(PS2_FRAME_FALLS))
                                        bitcnt <= bitcnt + 4'd1;
                                end
                            end
                            ST_ACK: begin
                                if (fall) begin
                                    if (!dat_s) begin
                                        state <= ST_WAIT_IDLE;
                                    end else begin
                                        tx_error <= 1'b1;
                                        state    <= ST_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (clk_s && dat_s) begin
                                    tx_done <= 1'b1;
                                    state   <= ST_IDLE;
                                end
                            end
                            default: begin
                                ps2_clk_oe <= 1'b0;
                                ps2_dat_oe <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector keyboard model clocks frames out of
// the host and compares them with a frame model built from the byte value.
module tb_ps2_host_tx;

    localparam int CLK_HZ     = 2_000_000;
    localparam int INHIBIT_US = 100;
    localparam int RTS_US     = 1;
    localparam int TIMEOUT_MS = 5;
    localparam int EXP_INH    = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int EXP_RTS    = CLK_HZ / 1_000_000 * RTS_US;
    localparam int EXP_TO     = CLK_HZ / 1000 * TIMEOUT_MS;

    logic       clk100 = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
    logic [2:0] dbg_state;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    // Wired-AND bus: either side can pull a line low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .RTS_US     (RTS_US),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .clk100     (clk100),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk100 = ~clk100;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic       prev_pulse = 1'b0;
    logic       busy_at_pulse = 1'b0;
    logic       busy_after = 1'b1;
    logic [1:0] oe_at_pulse = 2'b11;
    logic [10:0] exp_q[$];

    always @(negedge clk100) begin
        if (prev_pulse) busy_after = tx_busy;
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
        if (tx_done || tx_error) begin
            busy_at_pulse = tx_busy;
            oe_at_pulse   = {ps2_clk_oe, ps2_dat_oe};
        end
        prev_pulse = tx_done | tx_error;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference frame: bit 0 start, bits 1..8 data LSB first, 9 parity, 10 stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        int ones = 0;
        logic [10:0] f;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk100);
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk100);
        tx_start = 1'b0;
    endtask

    task automatic rts_phase();
        int n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < EXP_INH + 50) begin
            n++;
            @(negedge clk100);
        end
        check("inhibit_cycles", n, EXP_INH);
        n = 0;
        while (ps2_clk_oe && ps2_dat_oe && n < EXP_RTS + 50) begin
            n++;
            @(negedge clk100);
        end
        check("rts_cycles", n, EXP_RTS);
        check("rts_clk_released", {31'd0, ps2_clk_oe}, 0);
        check("rts_start_bit_low", {31'd0, ps2_dat_oe}, 1);
    endtask

    task automatic device_frame(input bit ack, input int h, output logic [10:0] got);
        got[0] = ps2_dat_in;
        cyc(h);
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            cyc(h);
            got[i] = ps2_dat_in;
            dev_clk = 1'b1;
            cyc(h);
        end
        if (ack) dev_dat = 1'b0;
        cyc(2);
        dev_clk = 1'b0;
        cyc(h);
        dev_clk = 1'b1;
        cyc(2);
        dev_dat = 1'b1;
    endtask

    task automatic wait_end(input int d0, input int e0, input bit exp_done);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < EXP_TO + 500) begin
            n++;
            @(negedge clk100);
        end
        cyc(2);
        check("done_count", done_cnt - d0, exp_done ? 1 : 0);
        check("error_count", err_cnt - e0, exp_done ? 0 : 1);
        check("busy_at_pulse", {31'd0, busy_at_pulse}, 1);
        check("busy_after_pulse", {31'd0, busy_after}, 0);
        check("oe_at_pulse", {30'd0, oe_at_pulse}, 0);
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int h,
                             output logic [10:0] got);
        int d0 = done_cnt;
        int e0 = err_cnt;
        exp_q.push_back(model_frame(d));
        start_tx(d);
        check("accept_busy", {31'd0, tx_busy}, 1);
        check("accept_clk_oe", {31'd0, ps2_clk_oe}, 1);
        check("accept_dat_oe", {31'd0, ps2_dat_oe}, 0);
        rts_phase();
        device_frame(ack, h, got);
        check("frame", {21'd0, got}, {21'd0, exp_q.pop_front()});
        wait_end(d0, e0, ack);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         h;
        logic       exp_parity;
        bit         exp_done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [10:0] got;
        int n, d0, e0;

        vecs[0] = '{8'hED, 1'b1, 20, 1'b1, 1'b1};
        vecs[1] = '{8'hF4, 1'b1, 12, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 25, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b0, 15, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 8,  1'b0, 1'b1};

        // Reset state
        cyc(4);
        check("reset_clk_oe", {31'd0, ps2_clk_oe}, 0);
        check("reset_dat_oe", {31'd0, ps2_dat_oe}, 0);
        check("reset_busy", {31'd0, tx_busy}, 0);
        check("reset_pulses", {30'd0, tx_done, tx_error}, 0);
        check("reset_state", {29'd0, dbg_state}, 0);
        rst = 1'b0;
        cyc(3);

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].data, vecs[i].ack, vecs[i].h, got);
            check("vec_parity", {31'd0, got[9]}, {31'd0, vecs[i].exp_parity});
            check("vec_idle_busy", {31'd0, tx_busy}, 0);
            cyc(5);
        end

        // 0x01 with a start issued mid-frame (dropped), then 0xFF requested
        // from the done cycle onward: accepted only once busy is low.
        d0 = done_cnt;
        start_tx(8'h01);
        rts_phase();
        tx_data = 8'hAA;
        tx_start = 1'b1;
        @(negedge clk100);
        tx_start = 1'b0;
        device_frame(1'b1, 10, got);
        check("b2b_first_frame", {21'd0, got}, {21'd0, model_frame(8'h01)});
        n = 0;
        while (!tx_done && n < 2000) begin
            n++;
            @(negedge clk100);
        end
        check("b2b_done_seen", {31'd0, tx_done}, 1);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk100);
        check("b2b_ignored_busy", {31'd0, tx_busy}, 0);
        check("b2b_ignored_clk_oe", {31'd0, ps2_clk_oe}, 0);
        @(negedge clk100);
        tx_start = 1'b0;
        check("b2b_accept_busy", {31'd0, tx_busy}, 1);
        check("b2b_accept_clk_oe", {31'd0, ps2_clk_oe}, 1);
        e0 = err_cnt;
        rts_phase();
        device_frame(1'b1, 10, got);
        check("b2b_second_frame", {21'd0, got}, {21'd0, model_frame(8'hFF)});
        wait_end(d0 + 1, e0, 1'b1);
        cyc(20);
        check("b2b_no_queue", {30'd0, ps2_clk_oe, tx_busy}, 0);

        // Timeout: device never clocks after release
        e0 = err_cnt;
        d0 = done_cnt;
        start_tx(8'h5A);
        rts_phase();
        n = 0;
        while (!tx_error && n < EXP_TO + 100) begin
            n++;
            @(negedge clk100);
        end
        check("timeout_cycles", n, EXP_TO);
        check("timeout_oe_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        cyc(3);
        check("timeout_no_done", done_cnt - d0, 0);
        check("timeout_one_error", err_cnt - e0, 1);
        check("timeout_busy", {31'd0, tx_busy}, 0);

        // Reset while bit 4 is being driven (0xEF: bit 4 is 0 -> data pulled low)
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hEF);
        rts_phase();
        cyc(10);
        for (int i = 1; i <= 4; i++) begin
            dev_clk = 1'b0; cyc(12);
            dev_clk = 1'b1; cyc(12);
        end
        dev_clk = 1'b0;
        cyc(6);
        check("bit4_driven_low", {31'd0, ps2_dat_oe}, 1);
        rst = 1'b1;
        @(negedge clk100);
        check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        check("rst_mid_busy", {31'd0, tx_busy}, 0);
        check("rst_mid_pulses", {30'd0, tx_done, tx_error}, 0);
        rst = 1'b0;
        dev_clk = 1'b1;
        cyc(10);
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_no_error", err_cnt - e0, 0);
        run_frame(8'hED, 1'b1, 20, got);

        // Randomized frames against the reference frame model
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            bit ack;
            int h;
            d   = 8'($urandom_range(0, 255));
            ack = ($urandom_range(0, 3) != 0);
            h   = $urandom_range(6, 30);
            run_frame(d, ack, h, got);
            cyc($urandom_range(1, 8));
        end

        check("never_done_and_error", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
